key_expander: RTL

KEY_EXPANDER -- requirements
Module: key_expander

---
 rtl/key_expander.sv | 124 ++++++++++++
 1 files changed

// File: rtl/key_expander.sv
// AES-128 key schedule: expands one cipher key into 11 stored round keys,
// one new round key per clock, with a level start / key_expanded handshake.
`timescale 1ns/1ps
module key_expander (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         start_key_exp,
  input  logic [127:0] key_in,
  input  logic [3:0]   round_sel,
  output logic [127:0] round_key,
  output logic         key_expanded,
  output logic         busy
);

  typedef enum logic [1:0] {StIdle, StExpand, StDone} state_e;

  state_e       state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] rk_q [11];
  logic [127:0] prev_key, next_key;
  logic [7:0]   rcon;
  logic [31:0]  rot_word, sub_word, t_word;
  logic [31:0]  n0, n1, n2, n3;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
           {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  always_comb begin
    rcon = 8'h00;
    case (rnd_q)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  always_comb begin
    prev_key = rk_q[rnd_q - 4'd1];
    rot_word = {prev_key[23:0], prev_key[31:24]};
    sub_word = {sbox(rot_word[31:24]), sbox(rot_word[23:16]),
                sbox(rot_word[15:8]), sbox(rot_word[7:0])};
    t_word   = sub_word ^ {rcon, 24'h000000};
    n0       = prev_key[127:96] ^ t_word;
    n1       = prev_key[95:64] ^ n0;
    n2       = prev_key[63:32] ^ n1;
    n3       = prev_key[31:0] ^ n2;
    next_key = {n0, n1, n2, n3};
  end

  always_comb begin
    state_d      = state_q;
    rnd_d        = rnd_q;
    busy         = 1'b0;
    key_expanded = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_key_exp) begin
          state_d = StExpand;
          rnd_d   = 4'd1;
        end
      end
      StExpand: begin
        busy = 1'b1;
        if (rnd_q == 4'd10) state_d = StDone;
        else                rnd_d   = rnd_q + 4'd1;
      end
      StDone: begin
        key_expanded = 1'b1;
        if (!start_key_exp) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= StIdle;
      rnd_q   <= 4'd0;
      for (int i = 0; i < 11; i++) rk_q[i] <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      if (state_q == StIdle && start_key_exp) rk_q[0] <= key_in;
      else if (state_q == StExpand)           rk_q[rnd_q] <= next_key;
    end
  end

  always_comb begin
    round_key = '0;
    if (round_sel <= 4'd10) round_key = rk_q[round_sel];
  end

endmodule
